hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 153 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Forwarding, load-use stall and branch-flush control for a 5-stage pipeline.
// Define HAZARD_STALL_CNT_EN to build the saturating stall-cycle counter.
module hazard_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [4:0]  id_Rn,
    input  logic [4:0]  id_Rm,
    input  logic [4:0]  id_Rd,
    input  logic        id_uses_Rn,
    input  logic        id_uses_Rm,
    input  logic        id_imm,
    input  logic        id_RegWrite,
    input  logic        id_MemRead,
    input  logic        id_branch_taken,
    output logic [1:0]  forwardA,
    output logic [1:0]  forwardB,
    output logic        stall,
    output logic        flush,
    output logic [31:0] stall_count
);

    localparam logic [4:0] XZR = 5'd31;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    logic       ex_valid_q, ex_valid_d;
    logic [4:0] ex_rn_q, ex_rn_d;
    logic [4:0] ex_rm_q, ex_rm_d;
    logic [4:0] ex_rd_q, ex_rd_d;
    logic       ex_imm_q, ex_imm_d;
    logic       ex_rw_q, ex_rw_d;
    logic       ex_mr_q, ex_mr_d;

    logic [4:0] mem_rd_q, mem_rd_d;
    logic       mem_rw_q, mem_rw_d;
    logic       mem_mr_q, mem_mr_d;

    logic [4:0] wb_rd_q, wb_rd_d;
    logic       wb_rw_q, wb_rw_d;

    logic       load_use_hit;
    logic       ex_capture;

    // Stage valid and MEM load flag are carried for visibility only.
    logic unused_stage_bits;
    assign unused_stage_bits = ex_valid_q ^ mem_mr_q;

    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic [4:0] m_rd, input logic m_rw,
                                           input logic [4:0] w_rd, input logic w_rw);
        logic [1:0] sel;
        sel = FWD_RF;
        if (m_rw && (m_rd != XZR) && (m_rd == src))
            sel = FWD_MEM;
        else if (w_rw && (w_rd != XZR) && (w_rd == src))
            sel = FWD_WB;
        return sel;
    endfunction

    always_comb begin
        forwardA = fwd_sel(ex_rn_q, mem_rd_q, mem_rw_q, wb_rd_q, wb_rw_q);
        forwardB = ex_imm_q ? FWD_RF : fwd_sel(ex_rm_q, mem_rd_q, mem_rw_q, wb_rd_q, wb_rw_q);
    end

    always_comb begin
        load_use_hit = ex_mr_q && ex_rw_q && (ex_rd_q != XZR) &&
                       ((id_uses_Rn && (id_Rn == ex_rd_q)) ||
                        (id_uses_Rm && (id_Rm == ex_rd_q)));
        stall = !reset && id_valid && load_use_hit;
        // A stalled branch is resolved again next cycle, so it never flushes now.
        flush = !reset && id_valid && id_branch_taken && !stall;
        ex_capture = !stall && !flush;
    end

    always_comb begin
        ex_valid_d = 1'b0;
        ex_rn_d    = XZR;
        ex_rm_d    = XZR;
        ex_rd_d    = XZR;
        ex_imm_d   = 1'b0;
        ex_rw_d    = 1'b0;
        ex_mr_d    = 1'b0;
        if (ex_capture) begin
            ex_valid_d = id_valid;
            ex_rn_d    = id_Rn;
            ex_rm_d    = id_Rm;
            ex_rd_d    = id_Rd;
            ex_imm_d   = id_imm;
            ex_rw_d    = id_RegWrite;
            ex_mr_d    = id_MemRead;
        end
        mem_rd_d = ex_rd_q;
        mem_rw_d = ex_rw_q;
        mem_mr_d = ex_mr_q;
        wb_rd_d  = mem_rd_q;
        wb_rw_d  = mem_rw_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid_q <= 1'b0;
            ex_rn_q    <= XZR;
            ex_rm_q    <= XZR;
            ex_rd_q    <= XZR;
            ex_imm_q   <= 1'b0;
            ex_rw_q    <= 1'b0;
            ex_mr_q    <= 1'b0;
            mem_rd_q   <= XZR;
            mem_rw_q   <= 1'b0;
            mem_mr_q   <= 1'b0;
            wb_rd_q    <= XZR;
            wb_rw_q    <= 1'b0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_rn_q    <= ex_rn_d;
            ex_rm_q    <= ex_rm_d;
            ex_rd_q    <= ex_rd_d;
            ex_imm_q   <= ex_imm_d;
            ex_rw_q    <= ex_rw_d;
            ex_mr_q    <= ex_mr_d;
            mem_rd_q   <= mem_rd_d;
            mem_rw_q   <= mem_rw_d;
            mem_mr_q   <= mem_mr_d;
            wb_rd_q    <= wb_rd_d;
            wb_rw_q    <= wb_rw_d;
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cnt_q <= 32'd0;
        else
            stall_cnt_q <= stall_cnt_d;
    end

    assign stall_count = stall_cnt_q;
`else
    assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed pipeline scenarios plus randomized traffic
// compared against an instruction-history reference model.
module tb_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_Rn, id_Rm, id_Rd;
    logic        id_uses_Rn, id_uses_Rm;
    logic        id_imm;
    logic        id_RegWrite, id_MemRead;
    logic        id_branch_taken;
    logic [1:0]  forwardA, forwardB;
    logic        stall, flush;
    logic [31:0] stall_count;

    hazard_ctrl dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid),
        .id_Rn(id_Rn), .id_Rm(id_Rm), .id_Rd(id_Rd),
        .id_uses_Rn(id_uses_Rn), .id_uses_Rm(id_uses_Rm),
        .id_imm(id_imm),
        .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead),
        .id_branch_taken(id_branch_taken),
        .forwardA(forwardA), .forwardB(forwardB),
        .stall(stall), .flush(flush),
        .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef HAZARD_STALL_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct packed {
        logic       v;
        logic [4:0] rn, rm, rd;
        logic       imm, rw, mr;
    } ins_t;

    // hist[0] is the instruction now in EX, hist[1] in MEM, hist[2] in WB.
    ins_t        hist[$];
    longint      exp_cnt;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic ins_t bubble();
        ins_t b;
        b.v = 1'b0; b.rn = 5'd31; b.rm = 5'd31; b.rd = 5'd31;
        b.imm = 1'b0; b.rw = 1'b0; b.mr = 1'b0;
        return b;
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < 3; i++) hist.push_back(bubble());
        exp_cnt = 0;
    endtask

    // Which older in-flight instruction supplies a source register.
    function automatic logic [1:0] m_fwd(input logic [4:0] src);
        for (int age = 1; age <= 2; age++)
            if (hist[age].rw && hist[age].rd != 5'd31 && hist[age].rd == src)
                return age[1:0];
        return 2'b00;
    endfunction

    function automatic logic m_stall();
        ins_t e;
        e = hist[0];
        return id_valid && e.mr && e.rw && e.rd != 5'd31 &&
               ((id_uses_Rn && id_Rn == e.rd) || (id_uses_Rm && id_Rm == e.rd));
    endfunction

    task automatic drive(input logic v, input logic [4:0] rn, input logic [4:0] rm,
                         input logic [4:0] rd, input logic urn, input logic urm,
                         input logic imm, input logic rw, input logic mr, input logic br);
        id_valid = v; id_Rn = rn; id_Rm = rm; id_Rd = rd;
        id_uses_Rn = urn; id_uses_Rm = urm; id_imm = imm;
        id_RegWrite = rw; id_MemRead = mr; id_branch_taken = br;
    endtask

    task automatic alu(input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm);
        drive(1, rn, rm, rd, 1, 1, 0, 1, 0, 0);
    endtask
    task automatic ldur(input logic [4:0] rd, input logic [4:0] rn);
        drive(1, rn, 5'd31, rd, 1, 0, 0, 1, 1, 0);
    endtask
    task automatic addi(input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm);
        drive(1, rn, rm, rd, 1, 0, 1, 1, 0, 0);
    endtask
    task automatic cbz(input logic [4:0] rn);
        drive(1, rn, 5'd31, 5'd31, 1, 0, 0, 0, 0, 1);
    endtask
    task automatic nop();
        drive(0, 5'd31, 5'd31, 5'd31, 0, 0, 0, 0, 0, 0);
    endtask

    // Compare every output with the model mid-cycle, then advance one edge.
    task automatic tick();
        logic s, f;
        ins_t cap;
        @(negedge clk);
        s = m_stall();
        f = id_branch_taken && id_valid && !s;
        check("fwdA", {30'd0, forwardA}, {30'd0, m_fwd(hist[0].rn)});
        check("fwdB", {30'd0, forwardB}, {30'd0, hist[0].imm ? 2'b00 : m_fwd(hist[0].rm)});
        check("stall", {31'd0, stall}, {31'd0, s});
        check("flush", {31'd0, flush}, {31'd0, f});
        check("stall_count", stall_count, exp_cnt[31:0]);
        @(posedge clk);
        if (s || f) begin
            cap = bubble();
        end else begin
            cap.v = id_valid; cap.rn = id_Rn; cap.rm = id_Rm; cap.rd = id_Rd;
            cap.imm = id_imm; cap.rw = id_RegWrite; cap.mr = id_MemRead;
        end
        hist.push_front(cap);
        void'(hist.pop_back());
        if (CNT_EN && s && exp_cnt < 64'hFFFF_FFFF) exp_cnt++;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_fwdA", {30'd0, forwardA}, 32'd0);
        check("rst_fwdB", {30'd0, forwardB}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_flush", {31'd0, flush}, 32'd0);
        check("rst_count", stall_count, 32'd0);
        @(posedge clk);
        #1;
        check("rst_edge_stall", {31'd0, stall}, 32'd0);
        check("rst_edge_fwdA", {30'd0, forwardA}, 32'd0);
        reset = 1'b0;
        model_reset();
        #1;
    endtask

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(0, 5))
            0: return 5'd1;
            1: return 5'd2;
            2: return 5'd3;
            3: return 5'd31;
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected below 1000000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        nop();
        model_reset();
        #1;
        do_reset();

        // ALU to ALU forward
        alu(1, 2, 3); tick();
        alu(4, 1, 5); tick();
        check("alu_fwdA", {30'd0, forwardA}, 32'd1);
        check("alu_fwdB", {30'd0, forwardB}, 32'd0);
        nop(); tick();

        // WB forward, then MEM priority over WB
        do_reset();
        alu(1, 2, 3); tick();
        nop(); tick();
        alu(6, 7, 1); tick();
        check("wb_fwdB", {30'd0, forwardB}, 32'd2);
        alu(1, 2, 3); tick();
        alu(1, 4, 5); tick();
        alu(8, 1, 1); tick();
        check("prio_fwdA", {30'd0, forwardA}, 32'd1);
        check("prio_fwdB", {30'd0, forwardB}, 32'd1);

        // Load-use: one stall cycle, bubble, then WB forward
        do_reset();
        ldur(2, 5); tick();
        alu(3, 2, 4); #1;
        check("lu_stall", {31'd0, stall}, 32'd1);
        tick();
        check("lu_stall_released", {31'd0, stall}, 32'd0);
        check("lu_bubble_fwdA", {30'd0, forwardA}, 32'd0);
        tick();
        check("lu_fwdA", {30'd0, forwardA}, 32'd2);
        check("lu_count", stall_count, CNT_EN ? 32'd1 : 32'd0);

        // XZR never stalls or forwards; immediate suppresses forwardB
        do_reset();
        ldur(31, 5); tick();
        alu(3, 31, 4); #1;
        check("xzr_stall", {31'd0, stall}, 32'd0);
        tick();
        check("xzr_fwdA", {30'd0, forwardA}, 32'd0);
        alu(1, 2, 3); tick();
        addi(2, 9, 1); tick();
        check("imm_fwdB", {30'd0, forwardB}, 32'd0);

        // Branch flush, and branch held by a load-use stall
        do_reset();
        cbz(5); #1;
        check("br_flush", {31'd0, flush}, 32'd1);
        tick();
        nop(); #1;
        check("br_flush_done", {31'd0, flush}, 32'd0);
        tick();
        ldur(2, 5); tick();
        cbz(2); #1;
        check("brlu_stall", {31'd0, stall}, 32'd1);
        check("brlu_noflush", {31'd0, flush}, 32'd0);
        tick();
        check("brlu_flush_next", {31'd0, flush}, 32'd1);
        tick();

        // Randomized traffic with occasional resets
        do_reset();
        for (int n = 0; n < 400; n++) begin
            logic v, rw, mr;
            if ($urandom_range(0, 59) == 0) begin
                nop();
                do_reset();
            end
            v  = ($urandom_range(0, 4) != 0);
            rw = v && ($urandom_range(0, 3) != 0);
            mr = rw && ($urandom_range(0, 2) == 0);
            drive(v, pick_reg(), pick_reg(), pick_reg(),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0), rw, mr,
                  ($urandom_range(0, 4) == 0));
            tick();
        end

        // Asynchronous reset in the middle of a stall
        nop(); tick(); tick();
        alu(7, 1, 1); tick();
        ldur(2, 7); tick();
        alu(3, 2, 4); #1;
        check("mid_stall", {31'd0, stall}, 32'd1);
        check("mid_fwdA", {30'd0, forwardA}, 32'd1);
        do_reset();
        tick();
        check("post_rst_fwdA", {30'd0, forwardA}, 32'd0);
        alu(9, 3, 3); tick();
        check("post_rst_capture", {30'd0, forwardA}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
